// File: rtl/ifu.sv
// Instruction fetch unit: issues one outstanding fetch at a time, holds the returned
// word for the decoder, and honours redirects that can arrive in any fetch phase.
module ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic        req_fire;
  logic [63:0] redirect_tgt;

  // Instructions are 4-byte aligned; the low target bits are dropped.
  function automatic logic [63:0] align_pc(input logic [63:0] a);
    return a & ~64'h3;
  endfunction

  function automatic logic [63:0] next_seq_pc(input logic [63:0] a);
    return a + 64'd4;
  endfunction

  assign redirect_tgt = align_pc(redirect_pc);

  // The request is the only output that must react within the cycle, so that a
  // redirect or halt suppresses issue immediately.
  assign imem_req_valid = !rst && (state == S_REQ) && !halt && !redirect_valid;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      state      <= S_REQ;
      inst_valid <= 1'b0;
      inst       <= 32'd0;
      inst_pc    <= 64'd0;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect_valid) begin
            pc <= redirect_tgt;
          end else if (req_fire) begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (redirect_valid) begin
            pc    <= redirect_tgt;
            // A response still in flight must be swallowed before refetching.
            state <= imem_resp_valid ? S_REQ : S_DRAIN;
          end else if (imem_resp_valid) begin
            inst       <= imem_resp_data;
            inst_pc    <= pc;
            pc         <= next_seq_pc(pc);
            state      <= S_HOLD;
            inst_valid <= 1'b1;
          end
        end

        S_HOLD: begin
          if (redirect_valid) begin
            pc         <= redirect_tgt;
            state      <= S_REQ;
            inst_valid <= 1'b0;
          end else if (inst_ready) begin
            state      <= S_REQ;
            inst_valid <= 1'b0;
          end
        end

        S_DRAIN: begin
          if (redirect_valid) begin
            pc <= redirect_tgt;
          end else if (imem_resp_valid) begin
            state <= S_REQ;
          end
        end

        default: begin
          state      <= S_REQ;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios plus a randomized run against a transaction-level model.
module tb_ifu;

  localparam logic [63:0] RPC  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] WRPC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst, halt, imem_req_ready, imem_resp_valid, inst_ready, redirect_valid;
  logic [31:0] imem_resp_data;
  logic [63:0] redirect_pc;

  logic        imem_req_valid, inst_valid;
  logic [63:0] imem_req_addr, inst_pc;
  logic [31:0] inst;

  logic        w_req_valid, w_inst_valid;
  logic [63:0] w_req_addr, w_inst_pc;
  logic [31:0] w_inst;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ifu dut (
    .clk(clk), .rst(rst), .halt(halt),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  ifu #(.RESET_PC(WRPC)) dut_w (
    .clk(clk), .rst(rst), .halt(halt),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(w_inst_valid), .inst(w_inst),
    .inst_pc(w_inst_pc), .inst_ready(inst_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; halt = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = 32'd0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; halt = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b1;
    imem_resp_data = 32'hDEAD_BEEF; inst_ready = 1'b1; redirect_valid = 1'b1;
    redirect_pc = 64'h1234;
    tick();
    tick();
    @(negedge clk);
    nvec++;
    if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL reset_req_valid got %0b want 0", imem_req_valid); end
    nvec++;
    if (inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== 64'd0) begin
      nerr++; $display("FAIL reset_inst got v=%0b i=%h pc=%h want 0/0/0", inst_valid, inst, inst_pc);
    end
    tick();
    rst = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    nvec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
      nerr++; $display("FAIL first_req got v=%0b a=%h want 1/%h", imem_req_valid, imem_req_addr, RPC);
    end
    tick();
  endtask

  task automatic test_sequential();
    int   got = 0;
    int   acc_cyc = 0;
    logic acc = 1'b0;
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b1; imem_resp_data = 32'h0000_0013;
    for (int c = 0; c < 40 && got < 3; c++) begin
      imem_resp_valid = acc;
      acc = 1'b0;
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin acc = 1'b1; acc_cyc = c; end
      if (inst_valid) begin
        nvec++;
        if (inst !== 32'h13 || inst_pc !== RPC + 64'(4 * got)) begin
          nerr++; $display("FAIL seq_inst%0d got %h@%h want 00000013@%h", got, inst, inst_pc, RPC + 64'(4 * got));
        end
        nvec++;
        if (c - acc_cyc != 2) begin
          nerr++; $display("FAIL seq_latency%0d got %0d want 2", got, c - acc_cyc);
        end
        got++;
      end
      tick();
    end
    imem_resp_valid = 1'b0;
    nvec++;
    if (got != 3) begin nerr++; $display("FAIL seq_count got %0d want 3", got); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    d = $urandom;
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = d;
    tick();
    imem_resp_valid = 1'b0; imem_req_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      nvec++;
      if (inst_valid !== 1'b1 || inst !== d || inst_pc !== RPC || imem_req_valid !== 1'b0) begin
        nerr++;
        $display("FAIL bp_hold%0d got v=%0b i=%h pc=%h rq=%0b want 1/%h/%h/0", k, inst_valid, inst, inst_pc, imem_req_valid, d, RPC);
      end
      tick();
    end
    inst_ready = 1'b1;
    @(negedge clk);
    nvec++;
    if (inst_valid !== 1'b1) begin nerr++; $display("FAIL bp_handshake got %0b want 1", inst_valid); end
    tick();
    inst_ready = 1'b0; imem_req_ready = 1'b0;
    @(negedge clk);
    nvec++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RPC + 64'd4) begin
      nerr++;
      $display("FAIL bp_after got v=%0b rq=%0b a=%h want 0/1/%h", inst_valid, imem_req_valid, imem_req_addr, RPC + 64'd4);
    end
    tick();
  endtask

  task automatic test_redirect_wait();
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0103;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    nvec++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      nerr++; $display("FAIL rw_drain got rq=%0b v=%0b want 0/0", imem_req_valid, inst_valid);
    end
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = $urandom;
    @(negedge clk);
    nvec++;
    if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL rw_resp_cycle got rq=%0b want 0", imem_req_valid); end
    tick();
    imem_resp_valid = 1'b0; imem_req_ready = 1'b0;
    @(negedge clk);
    nvec++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) begin
      nerr++;
      $display("FAIL rw_refetch got v=%0b rq=%0b a=%h want 0/1/0000000080000100", inst_valid, imem_req_valid, imem_req_addr);
    end
    tick();
  endtask

  task automatic test_redirect_hold();
    logic [63:0] tgt;
    tgt = {$urandom, $urandom} | 64'h3;
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = $urandom;
    tick();
    imem_resp_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = tgt; inst_ready = 1'b1;
    @(negedge clk);
    nvec++;
    if (inst_valid !== 1'b1) begin nerr++; $display("FAIL rh_held got %0b want 1", inst_valid); end
    tick();
    redirect_valid = 1'b0; inst_ready = 1'b0;
    @(negedge clk);
    nvec++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== (tgt & ~64'h3)) begin
      nerr++;
      $display("FAIL rh_squash got v=%0b rq=%0b a=%h want 0/1/%h", inst_valid, imem_req_valid, imem_req_addr, tgt & ~64'h3);
    end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    imem_req_ready = 1'b1;
    @(negedge clk);
    nvec++;
    if (w_req_valid !== 1'b1 || w_req_addr !== WRPC) begin
      nerr++; $display("FAIL wrap_first got v=%0b a=%h want 1/%h", w_req_valid, w_req_addr, WRPC);
    end
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
    tick();
    imem_resp_valid = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    nvec++;
    if (w_inst_valid !== 1'b1 || w_inst_pc !== WRPC) begin
      nerr++; $display("FAIL wrap_inst got v=%0b pc=%h want 1/%h", w_inst_valid, w_inst_pc, WRPC);
    end
    tick();
    inst_ready = 1'b0; imem_req_ready = 1'b0;
    @(negedge clk);
    nvec++;
    if (w_req_valid !== 1'b1 || w_req_addr !== 64'd0) begin
      nerr++; $display("FAIL wrap_second got v=%0b a=%h want 1/0", w_req_valid, w_req_addr);
    end
    tick();
  endtask

  task automatic test_halt_reset();
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    halt = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'hCAFE_0001;
    tick();
    imem_resp_valid = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    nvec++;
    if (inst_valid !== 1'b1 || inst !== 32'hCAFE_0001) begin
      nerr++; $display("FAIL halt_deliver got v=%0b i=%h want 1/cafe0001", inst_valid, inst);
    end
    tick();
    inst_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      nvec++;
      if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL halt_park%0d got %0b want 0", k, imem_req_valid); end
      tick();
    end
    halt = 1'b0;
    @(negedge clk);
    nvec++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC + 64'd4) begin
      nerr++; $display("FAIL halt_release got v=%0b a=%h want 1/%h", imem_req_valid, imem_req_addr, RPC + 64'd4);
    end
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1;
    tick();
    imem_resp_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    nvec++;
    if (inst_valid !== 1'b1) begin nerr++; $display("FAIL rst_hold_pre got %0b want 1", inst_valid); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
      nerr++;
      $display("FAIL rst_in_hold got v=%0b rq=%0b a=%h want 0/1/%h", inst_valid, imem_req_valid, imem_req_addr, RPC);
    end
    tick();
  endtask

  // Model tracks the fetch as transactions: an outstanding request, a request
  // to be discarded, or an instruction waiting for the decoder.
  task automatic test_random();
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_inst;
    logic        m_busy, m_drop, m_held, idle, exp_rv;
    do_reset();
    m_pc = RPC; m_ipc = 64'd0; m_inst = 32'd0;
    m_busy = 1'b0; m_drop = 1'b0; m_held = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      rst             = ($urandom_range(0, 79) == 0);
      halt            = ($urandom_range(0, 3) == 0);
      imem_req_ready  = $urandom_range(0, 1);
      imem_resp_valid = ($urandom_range(0, 2) == 0);
      imem_resp_data  = $urandom;
      inst_ready      = $urandom_range(0, 1);
      redirect_valid  = ($urandom_range(0, 9) == 0);
      redirect_pc     = {$urandom, $urandom};
      idle   = !m_busy && !m_drop && !m_held;
      exp_rv = !rst && idle && !halt && !redirect_valid;
      @(negedge clk);
      nvec++;
      if (imem_req_valid !== exp_rv || imem_req_addr !== m_pc) begin
        nerr++;
        $display("FAIL rnd_req%0d got v=%0b a=%h want %0b/%h", k, imem_req_valid, imem_req_addr, exp_rv, m_pc);
      end
      nvec++;
      if (inst_valid !== m_held || inst !== m_inst || inst_pc !== m_ipc) begin
        nerr++;
        $display("FAIL rnd_inst%0d got v=%0b i=%h pc=%h want %0b/%h/%h", k, inst_valid, inst, inst_pc, m_held, m_inst, m_ipc);
      end
      if (rst) begin
        m_pc = RPC; m_ipc = 64'd0; m_inst = 32'd0;
        m_busy = 1'b0; m_drop = 1'b0; m_held = 1'b0;
      end else if (redirect_valid) begin
        m_pc = redirect_pc & ~64'h3;
        if (m_busy) begin
          m_busy = 1'b0;
          m_drop = !imem_resp_valid;
        end
        m_held = 1'b0;
      end else if (exp_rv && imem_req_ready) begin
        m_busy = 1'b1;
      end else if (m_busy && imem_resp_valid) begin
        m_busy = 1'b0; m_held = 1'b1;
        m_inst = imem_resp_data; m_ipc = m_pc; m_pc = m_pc + 64'd4;
      end else if (m_held && inst_ready) begin
        m_held = 1'b0;
      end else if (m_drop && imem_resp_valid) begin
        m_drop = 1'b0;
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_halt_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
